cache_nway: RTL
===============

Name: cache_nway

Overview:
- Parametrised N-way set-associative, read-allocate instruction/data cache with multi-word lines and tree pseudo-LRU replacement.
- Sits between the pipeline fetch/load port and the memory bus; an owned refill FSM fetches whole lines on a miss.
- A store-update port patches resident lines; the external store buffer performs write-through.
- Provides single-cycle invalidate-all (flush) and hit/miss counters.

Parameters:
- WAYS, 4, associativity; power of 2, range 2..8.
- SETS, 64, sets per way; power of 2.
- WORDS, 4, 32-bit words per line; power of 2, range 1..16.
- ADDR_W, 32, byte address width.
- Derived: OFF_W = 2+log2(WORDS), IDX_W = log2(SETS), TAG_W = ADDR_W-IDX_W-OFF_W.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  1  read request.
- req_ready  out  1  request accepted this cycle when high with req_valid.
- req_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- resp_valid  out  1  one-cycle pulse: resp_rdata valid.
- resp_rdata  out  32  read data.
- upd_en  in  1  store-update strobe.
- upd_ready  out  1  update honoured when high with upd_en.
- upd_addr  in  ADDR_W  store address.
- upd_data  in  32  store data.
- upd_wstrb  in  4  byte enables.
- flush  in  1  invalidate all lines.
- mem_req_valid  out  1  line fetch request.
- mem_req_ready  in  1  bus accepts request.
- mem_req_addr  out  ADDR_W  line-aligned address (offset bits zero).
- mem_rvalid  in  1  refill beat valid.
- mem_rdata  in  32  refill beat data, words in ascending order.
- mem_rlast  in  1  final beat marker.
- hit_cnt  out  32  accepted requests that hit; wraps.
- miss_cnt  out  32  accepted requests that missed; wraps.

Behaviour:
- Reset (resetn low, async): state IDLE, all valid bits 0, PLRU bits 0, counters 0. resp_valid, mem_req_valid, req_ready and upd_ready are 0 while reset is asserted. Data arrays are not reset.
- States: IDLE, MREQ, REFILL, RESP.
- IDLE priority: flush > upd_en > req_valid.
- upd_ready = IDLE && !flush.
- req_ready = IDLE && !flush && !upd_en.
- Flush: clears every valid bit on the clock edge. PLRU bits and counters are unchanged.
- Lookup is combinational on tag/valid arrays in the acceptance cycle.
  - Hit: resp_valid=1 next cycle with the addressed word (1-cycle latency). hit_cnt+1. PLRU path updated to point away from the hit way. State stays IDLE, so back-to-back hits give one response per cycle.
  - Miss: miss_cnt+1. Latch address. Choose victim: lowest-index invalid way, else the PLRU victim. Go to MREQ.
- MREQ: mem_req_valid=1, mem_req_addr = latched line address. mem_req_valid is held until mem_req_ready, then go to REFILL.
- REFILL:
  - Each mem_rvalid beat writes mem_rdata to the victim way at beat counter k, then k+1.
  - The beat with k equal to the requested word offset is captured as the critical word.
  - On the beat with mem_rlast or k==WORDS-1 (whichever first): write tag and set valid for the victim, update PLRU, go to RESP.
  - mem_rvalid outside REFILL is ignored.
- RESP: resp_valid=1 with the critical word for one cycle, then IDLE. Earliest miss response is at acceptance + 3 + bus latency cycles.
- Update port: on a tag hit, byte-merge upd_data into the hit word per upd_wstrb; visible to lookups from the next cycle. On a miss, no effect (no allocate). Counters and PLRU are unaffected.
- PLRU: WAYS-1 bits per set, heap-ordered (node n has children 2n+1 and 2n+2).
  - Bit 0 selects the left subtree as victim; bit 1 selects the right.
  - An access sets each node on its path to point away from the accessed way.
- Reset mid-refill abandons the line (its valid bit stays 0). Any subsequent bus beats are ignored.
- req_valid/req_addr must stay stable until req_ready. upd_en is a single-cycle strobe only when upd_ready is high; otherwise the requester holds it.

Test Plan:
- Cold miss, WORDS=4: read 0x1008 → mem_req_addr=0x1000. Beats 0xA0..0xA3 → resp_rdata=0xA2 in RESP. miss_cnt=1. Reread 0x100C → resp_valid exactly 1 cycle after acceptance with 0xA3, hit_cnt=1.
- Replacement, WAYS=4, SETS=64, WORDS=4 (set stride 0x400): miss tags into set 0 at 0x0000, 0x0400, 0x0800, 0x0C00 (fill ways 0..3), then hit 0x0000, then miss 0x1000 → refill overwrites way 2. Reread 0x0800 misses, reread 0x0000 and 0x0400 hit.
- Update: resident word 0x11223344; upd_wstrb=0101, upd_data=0xAABBCCDD → read returns 0x11BB33DD. Update to a non-resident address → a later read misses; memory data returned unchanged.
- Priority: flush, upd_en and req_valid all in the same IDLE cycle → req_ready=0, upd_ready=0, all lines invalid. A following read of a previously resident address misses.
- Early rlast: mem_rlast on beat 1 with WORDS=4 → line marked valid and response delivered; only words 0..1 are defined.
- Reset mid-refill: resetn low after 2 beats, release, then further mem_rvalid beats arrive → no writes and no resp_valid. Re-reading the same address misses; counters read 0.

Source files
------------

// File: rtl/cache_nway.sv
// N-way set-associative, read-allocate cache with multi-word lines, tree pseudo-LRU
// replacement, a store-update (byte-merge) port and a line-refill FSM on the memory bus.
module cache_nway #(
  parameter int WAYS   = 4,
  parameter int SETS   = 64,
  parameter int WORDS  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  input  logic              upd_en,
  output logic              upd_ready,
  input  logic [ADDR_W-1:0] upd_addr,
  input  logic [31:0]       upd_data,
  input  logic [3:0]        upd_wstrb,
  input  logic              flush,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rlast,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);

  localparam int OFF_W  = 2 + $clog2(WORDS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int WAY_W  = $clog2(WAYS);
  localparam int WOFF_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int DA_W   = WAY_W + IDX_W + WOFF_W;
  localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'((1 << OFF_W) - 1);
  localparam logic [WOFF_W-1:0] LAST_BEAT = WOFF_W'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, MREQ, REFILL, RESP} state_e;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return TAG_W'(a >> (OFF_W + IDX_W));
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'(a >> OFF_W);
  endfunction

  function automatic logic [WOFF_W-1:0] addr_word(input logic [ADDR_W-1:0] a);
    return WOFF_W'((a >> 2) & ADDR_W'(WORDS - 1));
  endfunction

  // Heap-ordered tree: a node value of 0 sends the victim search left, 1 right.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] bits);
    int   node;
    logic b;
    plru_victim = '0;
    node        = 0;
    for (int l = 0; l < WAY_W; l++) begin
      b                         = bits[node];
      plru_victim[WAY_W-1-l]    = b;
      node                      = 2 * node + 1 + int'(b);
    end
  endfunction

  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits,
                                                 input logic [WAY_W-1:0] way);
    int   node;
    logic b;
    plru_touch = bits;
    node       = 0;
    for (int l = 0; l < WAY_W; l++) begin
      b                = way[WAY_W-1-l];
      plru_touch[node] = ~b;
      node             = 2 * node + 1 + int'(b);
    end
  endfunction

  state_e                        state_q, state_d;
  logic [WAYS-1:0][SETS-1:0]     valid_q, valid_d;
  logic [SETS-1:0][WAYS-2:0]     plru_q, plru_d;
  logic [31:0]                   hit_cnt_q, hit_cnt_d;
  logic [31:0]                   miss_cnt_q, miss_cnt_d;
  logic                          hit_resp_q, hit_resp_d;
  logic [31:0]                   hit_data_q, hit_data_d;
  logic [31:0]                   crit_q, crit_d;
  logic [ADDR_W-1:0]             line_addr_q, line_addr_d;
  logic [WOFF_W-1:0]             word_q, word_d;
  logic [WOFF_W-1:0]             beat_q, beat_d;
  logic [WAY_W-1:0]              victim_q, victim_d;

  logic [TAG_W-1:0]              tag_q [WAYS][SETS];
  logic [31:0]                   data_q [2**DA_W];

  logic [TAG_W-1:0]  req_tag, upd_tag, line_tag;
  logic [IDX_W-1:0]  req_idx, upd_idx, line_idx;
  logic [WOFF_W-1:0] req_word, upd_word;
  logic              req_hit, upd_hit, free_ok;
  logic [WAY_W-1:0]  req_way, upd_way, free_way;
  logic [31:0]       upd_merged;
  logic              req_fire, upd_fire;
  logic              data_we, tag_we;
  logic [DA_W-1:0]   data_waddr;
  logic [31:0]       data_wdata;

  assign req_tag  = addr_tag(req_addr);
  assign req_idx  = addr_idx(req_addr);
  assign req_word = addr_word(req_addr);
  assign upd_tag  = addr_tag(upd_addr);
  assign upd_idx  = addr_idx(upd_addr);
  assign upd_word = addr_word(upd_addr);
  assign line_tag = addr_tag(line_addr_q);
  assign line_idx = addr_idx(line_addr_q);

  assign upd_ready     = resetn && (state_q == IDLE) && !flush;
  assign req_ready     = upd_ready && !upd_en;
  assign upd_fire      = upd_en && upd_ready;
  assign req_fire      = req_valid && req_ready;
  assign mem_req_valid = (state_q == MREQ);
  assign mem_req_addr  = line_addr_q;
  assign resp_valid    = hit_resp_q || (state_q == RESP);
  assign resp_rdata    = (state_q == RESP) ? crit_q : hit_data_q;
  assign hit_cnt       = hit_cnt_q;
  assign miss_cnt      = miss_cnt_q;

  // Descending scan so the lowest-index match or free way is the one kept.
  always_comb begin
    req_hit  = 1'b0;
    req_way  = '0;
    upd_hit  = 1'b0;
    upd_way  = '0;
    free_ok  = 1'b0;
    free_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[w][req_idx] && tag_q[w][req_idx] == req_tag) begin
        req_hit = 1'b1;
        req_way = WAY_W'(w);
      end
      if (valid_q[w][upd_idx] && tag_q[w][upd_idx] == upd_tag) begin
        upd_hit = 1'b1;
        upd_way = WAY_W'(w);
      end
      if (!valid_q[w][req_idx]) begin
        free_ok  = 1'b1;
        free_way = WAY_W'(w);
      end
    end
  end

  always_comb begin
    upd_merged = data_q[{upd_way, upd_idx, upd_word}];
    for (int b = 0; b < 4; b++) begin
      if (upd_wstrb[b]) upd_merged[8*b +: 8] = upd_data[8*b +: 8];
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d     = state_q;
    valid_d     = valid_q;
    plru_d      = plru_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    hit_resp_d  = 1'b0;
    hit_data_d  = hit_data_q;
    crit_d      = crit_q;
    line_addr_d = line_addr_q;
    word_d      = word_q;
    beat_d      = beat_q;
    victim_d    = victim_q;
    data_we     = 1'b0;
    data_waddr  = '0;
    data_wdata  = '0;
    tag_we      = 1'b0;

    // A flush during a refill still lets the incoming line become valid: its data is fresh.
    if (flush) valid_d = '0;

    unique case (state_q)
      IDLE: begin
        if (upd_fire) begin
          if (upd_hit) begin
            data_we    = 1'b1;
            data_waddr = {upd_way, upd_idx, upd_word};
            data_wdata = upd_merged;
          end
        end else if (req_fire) begin
          if (req_hit) begin
            hit_resp_d      = 1'b1;
            hit_data_d      = data_q[{req_way, req_idx, req_word}];
            hit_cnt_d       = hit_cnt_q + 32'd1;
            plru_d[req_idx] = plru_touch(plru_q[req_idx], req_way);
          end else begin
            miss_cnt_d  = miss_cnt_q + 32'd1;
            line_addr_d = req_addr & ~OFF_MASK;
            word_d      = req_word;
            beat_d      = '0;
            victim_d    = free_ok ? free_way : plru_victim(plru_q[req_idx]);
            state_d     = MREQ;
          end
        end
      end
      MREQ: begin
        if (mem_req_ready) state_d = REFILL;
      end
      REFILL: begin
        if (mem_rvalid) begin
          data_we    = 1'b1;
          data_waddr = {victim_q, line_idx, beat_q};
          data_wdata = mem_rdata;
          beat_d     = beat_q + 1'b1;
          if (beat_q == word_q) crit_d = mem_rdata;
          if (mem_rlast || beat_q == LAST_BEAT) begin
            tag_we                     = 1'b1;
            valid_d[victim_q][line_idx] = 1'b1;
            plru_d[line_idx]           = plru_touch(plru_q[line_idx], victim_q);
            state_d                    = RESP;
          end
        end
      end
      RESP: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      plru_q      <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      hit_resp_q  <= 1'b0;
      hit_data_q  <= '0;
      crit_q      <= '0;
      line_addr_q <= '0;
      word_q      <= '0;
      beat_q      <= '0;
      victim_q    <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      plru_q      <= plru_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      hit_resp_q  <= hit_resp_d;
      hit_data_q  <= hit_data_d;
      crit_q      <= crit_d;
      line_addr_q <= line_addr_d;
      word_q      <= word_d;
      beat_q      <= beat_d;
      victim_q    <= victim_d;
    end
  end

  // NOTE: tag and data arrays are deliberately not reset; the valid bits alone decide residency.
  always_ff @(posedge clk) begin
    if (data_we) data_q[data_waddr] <= data_wdata;
    if (tag_we)  tag_q[victim_q][line_idx] <= line_tag;
  end

endmodule
